// File: rtl/i2c_dbg_bus_bridge_if.sv
// Debug-bus interface between the I2C debug bridge and the debug interconnect.
//   master modport : bridge side (drives request, address, write data, byte enables)
//   slave  modport : interconnect side (drives ack, read data, error)
// Signals:
//   dbg_req   request, held until dbg_ack
//   dbg_we    1=write, 0=read
//   dbg_addr  word address (bits[1:0]=0)
//   dbg_wdata write data
//   dbg_be    byte enables
//   dbg_ack   completion pulse
//   dbg_rdata read data, valid with dbg_ack
//   dbg_err   error flag, valid with dbg_ack
interface i2c_dbg_bus_bridge_if;
  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic [3:0]  dbg_be;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        dbg_err;

  modport master (
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_be,
    input  dbg_ack, dbg_rdata, dbg_err
  );

  modport slave (
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_be,
    output dbg_ack, dbg_rdata, dbg_err
  );
endinterface

// File: rtl/i2c_dbg_bus_bridge.sv
// Bridge from the byte-level register interface of the I2C debug subordinate
// to 32-bit debug-bus transactions. A write transaction carries a 4-byte
// little-endian address pointer followed by little-endian data bytes; reads
// fetch whole words and serve them byte by byte with pointer auto-increment.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   i2c_start / i2c_stop      framing pulses from the subordinate
//   i2c_wr_req/_data/_ready   written-byte handshake (req level, ready pulse)
//   i2c_rd_req/_data/_ready   read-byte handshake (req level, ready pulse)
//   dbg                       debug-bus master port
//   err_sticky                set on bus error or timeout, cleared by start in IDLE
//   busy                      high whenever the FSM is not IDLE
module i2c_dbg_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        i2c_start,
  input  logic                        i2c_stop,
  input  logic                        i2c_wr_req,
  input  logic [7:0]                  i2c_wr_data,
  output logic                        i2c_wr_ready,
  input  logic                        i2c_rd_req,
  output logic [7:0]                  i2c_rd_data,
  output logic                        i2c_rd_ready,
  i2c_dbg_bus_bridge_if.master        dbg,
  output logic                        err_sticky,
  output logic                        busy
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ACTIVE, BUS_WR, BUS_RD, RESP} state_e;

  state_e        state;
  logic [31:0]   ptr;
  logic [2:0]    acnt;
  logic [1:0]    dcnt;
  logic [31:0]   wbuf;
  logic [3:0]    beAcc;
  logic [31:0]   rbuf;
  logic [TW-1:0] tmoCnt;
  logic          ignoreReq;
  logic          stopPend;
  logic          startPend;
  logic          oweWr;
  logic          oweRd;

  // Incoming write byte merged into the pointer / data word at the current lane.
  logic [31:0] ptrIns;
  logic [31:0] wbufIns;

  for (genvar gi = 0; gi < 4; gi++) begin : gLane
    assign ptrIns[8*gi +: 8]  = (acnt[1:0] == 2'(gi)) ? i2c_wr_data : ptr[8*gi +: 8];
    assign wbufIns[8*gi +: 8] = (dcnt == 2'(gi))      ? i2c_wr_data : wbuf[8*gi +: 8];
  end

  // The subordinate drops its request one cycle after seeing ready, so the
  // pulse cycle and the cycle after it must not start a new byte.
  logic reqOk;
  assign reqOk = !i2c_wr_ready && !i2c_rd_ready && !ignoreReq;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      ptr           <= '0;
      acnt          <= '0;
      dcnt          <= '0;
      wbuf          <= '0;
      beAcc         <= '0;
      rbuf          <= '0;
      tmoCnt        <= '0;
      ignoreReq     <= 1'b0;
      stopPend      <= 1'b0;
      startPend     <= 1'b0;
      oweWr         <= 1'b0;
      oweRd         <= 1'b0;
      i2c_wr_ready  <= 1'b0;
      i2c_rd_ready  <= 1'b0;
      i2c_rd_data   <= '0;
      dbg.dbg_req   <= 1'b0;
      dbg.dbg_we    <= 1'b0;
      dbg.dbg_addr  <= '0;
      dbg.dbg_wdata <= '0;
      dbg.dbg_be    <= '0;
      err_sticky    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      i2c_wr_ready <= 1'b0;
      i2c_rd_ready <= 1'b0;
      ignoreReq    <= i2c_wr_ready | i2c_rd_ready;

      case (state)
        IDLE: begin
          if (i2c_start) begin
            state      <= ACTIVE;
            busy       <= 1'b1;
            err_sticky <= 1'b0;
            acnt       <= '0;
            dcnt       <= '0;
            beAcc      <= '0;
          end
        end

        ACTIVE: begin
          if (i2c_stop) begin
            if (beAcc != 4'b0000) begin
              // Flush the partially filled word; nothing is owed to the I2C side.
              dbg.dbg_req   <= 1'b1;
              dbg.dbg_we    <= 1'b1;
              dbg.dbg_addr  <= ptr;
              dbg.dbg_wdata <= wbuf;
              dbg.dbg_be    <= beAcc;
              tmoCnt        <= '0;
              oweWr         <= 1'b0;
              oweRd         <= 1'b0;
              stopPend      <= 1'b1;
              startPend     <= 1'b0;
              state         <= BUS_WR;
            end else begin
              // Also discards any partially served read word.
              state <= IDLE;
              busy  <= 1'b0;
              dcnt  <= '0;
            end
          end else if (i2c_start) begin
            acnt  <= '0;
            dcnt  <= '0;
            beAcc <= '0;
          end else if (reqOk && i2c_wr_req) begin
            if (acnt != 3'd4) begin
              ptr          <= (acnt == 3'd3) ? {ptrIns[31:2], 2'b00} : ptrIns;
              acnt         <= acnt + 3'd1;
              i2c_wr_ready <= 1'b1;
            end else begin
              wbuf  <= wbufIns;
              beAcc <= beAcc | (4'b0001 << dcnt);
              dcnt  <= dcnt + 2'd1;
              if (dcnt == 2'd3) begin
                // Full word: keep the last byte stretched until the bus answers.
                dbg.dbg_req   <= 1'b1;
                dbg.dbg_we    <= 1'b1;
                dbg.dbg_addr  <= ptr;
                dbg.dbg_wdata <= wbufIns;
                dbg.dbg_be    <= 4'hF;
                tmoCnt        <= '0;
                oweWr         <= 1'b1;
                oweRd         <= 1'b0;
                stopPend      <= 1'b0;
                startPend     <= 1'b0;
                state         <= BUS_WR;
              end else begin
                i2c_wr_ready <= 1'b1;
              end
            end
          end else if (reqOk && i2c_rd_req) begin
            if (dcnt == 2'd0) begin
              dbg.dbg_req  <= 1'b1;
              dbg.dbg_we   <= 1'b0;
              dbg.dbg_addr <= ptr;
              dbg.dbg_be   <= 4'hF;
              tmoCnt       <= '0;
              oweWr        <= 1'b0;
              oweRd        <= 1'b1;
              stopPend     <= 1'b0;
              startPend    <= 1'b0;
              state        <= BUS_RD;
            end else begin
              i2c_rd_data  <= rbuf[{dcnt, 3'b000} +: 8];
              i2c_rd_ready <= 1'b1;
              dcnt         <= dcnt + 2'd1;
              if (dcnt == 2'd3) ptr <= ptr + 32'd4;
            end
          end
        end

        BUS_WR, BUS_RD: begin
          // Framing events during a bus cycle are replayed once it completes;
          // the most recent one wins.
          if (i2c_stop) begin
            stopPend  <= 1'b1;
            startPend <= 1'b0;
          end else if (i2c_start) begin
            startPend <= 1'b1;
            stopPend  <= 1'b0;
          end
          if (dbg.dbg_ack || (tmoCnt == TMO_LAST)) begin
            dbg.dbg_req <= 1'b0;
            state       <= RESP;
            if (!dbg.dbg_ack || dbg.dbg_err) err_sticky <= 1'b1;
            if (state == BUS_WR) begin
              ptr   <= ptr + 32'd4;
              beAcc <= '0;
              dcnt  <= '0;
            end else begin
              rbuf <= (dbg.dbg_ack && !dbg.dbg_err) ? dbg.dbg_rdata : ERR_DATA;
            end
          end else begin
            tmoCnt <= tmoCnt + TW'(1);
          end
        end

        RESP: begin
          if (oweWr) i2c_wr_ready <= 1'b1;
          if (oweRd) begin
            i2c_rd_data  <= rbuf[7:0];
            i2c_rd_ready <= 1'b1;
            dcnt         <= 2'd1;
          end
          oweWr     <= 1'b0;
          oweRd     <= 1'b0;
          stopPend  <= 1'b0;
          startPend <= 1'b0;
          if (i2c_start || (startPend && !i2c_stop)) begin
            state <= ACTIVE;
            acnt  <= '0;
            dcnt  <= '0;
            beAcc <= '0;
          end else if (i2c_stop || stopPend) begin
            state <= IDLE;
            busy  <= 1'b0;
            dcnt  <= '0;
          end else begin
            state <= ACTIVE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_dbg_bus_bridge.sv
// Self-checking bench for i2c_dbg_bus_bridge: a table of I2C byte operations
// with expected read bytes, a scoreboard of expected debug-bus transactions
// consumed by a responding bus model, and hand-written corner sequences.
module tb_i2c_dbg_bus_bridge;

  localparam int BOUND = 3000;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       i2c_start = 1'b0;
  logic       i2c_stop = 1'b0;
  logic       i2c_wr_req = 1'b0;
  logic [7:0] i2c_wr_data = 8'h00;
  logic       i2c_wr_ready;
  logic       i2c_rd_req = 1'b0;
  logic [7:0] i2c_rd_data;
  logic       i2c_rd_ready;
  logic       err_sticky;
  logic       busy;

  always #5 clk = ~clk;

  i2c_dbg_bus_bridge_if busIf();

  i2c_dbg_bus_bridge dut (
    .clk          (clk),
    .rstn         (rstn),
    .i2c_start    (i2c_start),
    .i2c_stop     (i2c_stop),
    .i2c_wr_req   (i2c_wr_req),
    .i2c_wr_data  (i2c_wr_data),
    .i2c_wr_ready (i2c_wr_ready),
    .i2c_rd_req   (i2c_rd_req),
    .i2c_rd_data  (i2c_rd_data),
    .i2c_rd_ready (i2c_rd_ready),
    .dbg          (busIf),
    .err_sticky   (err_sticky),
    .busy         (busy)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] wmask;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
    logic        noAck;
  } busTxn_t;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_WR    = 2'd2;
  localparam logic [1:0] OP_RD    = 2'd3;

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic [7:0] exp;
    logic       hasBus;
    busTxn_t    bus;
  } vec_t;

  busTxn_t expBus[$];
  vec_t    vecs[$];

  int checks = 0;
  int errors = 0;
  int wrReadyCnt = 0;
  int rdReadyCnt = 0;
  int lastReqCycles = 0;
  int ackDelay = 2;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  function automatic busTxn_t bw(input logic [31:0] a, input logic [31:0] d,
                                 input logic [31:0] m, input logic [3:0] be, input logic noAck);
    busTxn_t t;
    t.we = 1'b1; t.addr = a; t.wdata = d; t.wmask = m; t.be = be;
    t.rdata = 32'h0; t.err = 1'b0; t.noAck = noAck;
    return t;
  endfunction

  function automatic busTxn_t br(input logic [31:0] a, input logic [31:0] rd, input logic noAck);
    busTxn_t t;
    t.we = 1'b0; t.addr = a; t.wdata = 32'h0; t.wmask = 32'h0; t.be = 4'hF;
    t.rdata = rd; t.err = 1'b0; t.noAck = noAck;
    return t;
  endfunction

  task automatic addV(input logic [1:0] op, input logic [7:0] d, input logic [7:0] e,
                      input logic hb, input busTxn_t b);
    vec_t v;
    v.op = op; v.data = d; v.exp = e; v.hasBus = hb; v.bus = b;
    vecs.push_back(v);
  endtask

  // Ready pulse counters (sampled mid-cycle).
  always @(negedge clk) begin
    if (i2c_wr_ready) wrReadyCnt++;
    if (i2c_rd_ready) rdReadyCnt++;
  end

  // Debug-bus responder: pops the expected transaction on each new request,
  // compares it, and acks after ackDelay cycles unless told never to ack.
  initial begin
    logic        inCycle;
    logic        acked;
    logic        stableBad;
    int          waitCnt;
    int          reqCycles;
    busTxn_t     cur;
    logic        capWe;
    logic [31:0] capAddr, capWdata;
    logic [3:0]  capBe;
    inCycle = 1'b0; acked = 1'b0; stableBad = 1'b0; waitCnt = 0; reqCycles = 0;
    cur = br(32'h0, 32'h0, 1'b0);
    capWe = 1'b0; capAddr = '0; capWdata = '0; capBe = '0;
    busIf.dbg_ack = 1'b0;
    busIf.dbg_rdata = 32'h0;
    busIf.dbg_err = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      busIf.dbg_ack = 1'b0;
      busIf.dbg_err = 1'b0;
      if (busIf.dbg_req) begin
        if (!inCycle) begin
          inCycle = 1'b1; acked = 1'b0; stableBad = 1'b0; reqCycles = 0;
          waitCnt = ackDelay;
          capWe = busIf.dbg_we; capAddr = busIf.dbg_addr;
          capWdata = busIf.dbg_wdata; capBe = busIf.dbg_be;
          if (expBus.size() == 0) begin
            checks++; errors++;
            $display("FAIL bus_unexpected: got we=%b addr %h expected no bus cycle", capWe, capAddr);
            cur = br(32'h0, 32'h0, 1'b0);
          end else begin
            cur = expBus.pop_front();
            chk("bus_we", {31'b0, capWe}, {31'b0, cur.we});
            chk("bus_addr", capAddr, cur.addr);
            if (cur.we) begin
              chk("bus_be", {28'b0, capBe}, {28'b0, cur.be});
              chk("bus_wdata", capWdata & cur.wmask, cur.wdata & cur.wmask);
            end
          end
        end else if (busIf.dbg_we !== capWe || busIf.dbg_addr !== capAddr ||
                     busIf.dbg_wdata !== capWdata || busIf.dbg_be !== capBe) begin
          stableBad = 1'b1;
        end
        reqCycles++;
        if (!acked && !cur.noAck) begin
          if (waitCnt == 0) begin
            busIf.dbg_ack = 1'b1;
            busIf.dbg_rdata = cur.rdata;
            busIf.dbg_err = cur.err;
            acked = 1'b1;
          end else begin
            waitCnt--;
          end
        end
      end else if (inCycle) begin
        inCycle = 1'b0;
        lastReqCycles = reqCycles;
        chk("bus_stable", {31'b0, stableBad}, 32'h0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    i2c_start = 1'b1;
    tick(1);
    i2c_start = 1'b0;
  endtask

  task automatic pulseStop();
    i2c_stop = 1'b1;
    tick(1);
    i2c_stop = 1'b0;
  endtask

  // Request stays high through the ready pulse and one more cycle, as the
  // subordinate deasserts one cycle late.
  task automatic wrByte(input logic [7:0] d);
    int n;
    n = 0;
    i2c_wr_data = d;
    i2c_wr_req = 1'b1;
    while (n < BOUND) begin
      @(negedge clk);
      if (i2c_wr_ready) break;
      n++;
    end
    if (n >= BOUND) begin
      checks++; errors++;
      $display("FAIL wr_timeout: got no i2c_wr_ready expected a pulse for byte %h", d);
    end
    tick(2);
    i2c_wr_req = 1'b0;
  endtask

  task automatic rdByte(output logic [7:0] d);
    int n;
    n = 0;
    d = 8'hxx;
    i2c_rd_req = 1'b1;
    while (n < BOUND) begin
      @(negedge clk);
      if (i2c_rd_ready) begin
        d = i2c_rd_data;
        break;
      end
      n++;
    end
    if (n >= BOUND) begin
      checks++; errors++;
      $display("FAIL rd_timeout: got no i2c_rd_ready expected a pulse");
    end
    tick(2);
    i2c_rd_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    busTxn_t    nb;
    logic [7:0] got;
    int         c0, c1, n;

    nb = br(32'h0, 32'h0, 1'b0);

    // Reset state
    tick(3);
    chk("rst_dbg_req", {31'b0, busIf.dbg_req}, 32'h0);
    chk("rst_dbg_we", {31'b0, busIf.dbg_we}, 32'h0);
    chk("rst_dbg_addr", busIf.dbg_addr, 32'h0);
    chk("rst_dbg_wdata", busIf.dbg_wdata, 32'h0);
    chk("rst_dbg_be", {28'b0, busIf.dbg_be}, 32'h0);
    chk("rst_wr_ready", {31'b0, i2c_wr_ready}, 32'h0);
    chk("rst_rd_ready", {31'b0, i2c_rd_ready}, 32'h0);
    chk("rst_rd_data", {24'b0, i2c_rd_data}, 32'h0);
    chk("rst_err_sticky", {31'b0, err_sticky}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    rstn = 1'b1;
    tick(2);

    // Full-word write, pointer check via a following read, pointer-then-read with repeated start
    addV(OP_START, 8'h00, 8'h00, 1'b0, nb);
    addV(OP_WR, 8'h10, 8'h00, 1'b0, nb);
    addV(OP_WR, 8'h00, 8'h00, 1'b0, nb);
    addV(OP_WR, 8'h00, 8'h00, 1'b0, nb);
    addV(OP_WR, 8'h40, 8'h00, 1'b0, nb);
    addV(OP_WR, 8'h11, 8'h00, 1'b0, nb);
    addV(OP_WR, 8'h22, 8'h00, 1'b0, nb);
    addV(OP_WR, 8'h33, 8'h00, 1'b0, nb);
    addV(OP_WR, 8'h44, 8'h00, 1'b1, bw(32'h4000_0010, 32'h4433_2211, 32'hFFFF_FFFF, 4'hF, 1'b0));
    addV(OP_STOP, 8'h00, 8'h00, 1'b0, nb);
    addV(OP_START, 8'h00, 8'h00, 1'b0, nb);
    addV(OP_RD, 8'h00, 8'h78, 1'b1, br(32'h4000_0014, 32'h1234_5678, 1'b0));
    addV(OP_STOP, 8'h00, 8'h00, 1'b0, nb);
    addV(OP_START, 8'h00, 8'h00, 1'b0, nb);
    addV(OP_WR, 8'h20, 8'h00, 1'b0, nb);
    addV(OP_WR, 8'h00, 8'h00, 1'b0, nb);
    addV(OP_WR, 8'h00, 8'h00, 1'b0, nb);
    addV(OP_WR, 8'h40, 8'h00, 1'b0, nb);
    addV(OP_START, 8'h00, 8'h00, 1'b0, nb);
    addV(OP_RD, 8'h00, 8'hD4, 1'b1, br(32'h4000_0020, 32'hA1B2_C3D4, 1'b0));
    addV(OP_RD, 8'h00, 8'hC3, 1'b0, nb);
    addV(OP_RD, 8'h00, 8'hB2, 1'b0, nb);
    addV(OP_RD, 8'h00, 8'hA1, 1'b0, nb);
    addV(OP_RD, 8'h00, 8'h04, 1'b1, br(32'h4000_0024, 32'h0102_0304, 1'b0));
    addV(OP_RD, 8'h00, 8'h03, 1'b0, nb);
    addV(OP_STOP, 8'h00, 8'h00, 1'b0, nb);

    c0 = wrReadyCnt;
    c1 = rdReadyCnt;
    foreach (vecs[i]) begin
      if (vecs[i].hasBus) expBus.push_back(vecs[i].bus);
      case (vecs[i].op)
        OP_START: pulseStart();
        OP_STOP:  pulseStop();
        OP_WR:    wrByte(vecs[i].data);
        default: begin
          rdByte(got);
          chk($sformatf("rd_byte[%0d]", i), {24'b0, got}, {24'b0, vecs[i].exp});
        end
      endcase
    end
    tick(4);
    chk("tbl_bus_left", expBus.size(), 32'd0);
    chk("tbl_wr_pulses", wrReadyCnt - c0, 32'd12);
    chk("tbl_rd_pulses", rdReadyCnt - c1, 32'd7);

    // Request held three cycles per byte: exactly one byte consumed each time,
    // so the pointer is exactly the four bytes sent.
    pulseStart();
    c0 = wrReadyCnt;
    wrByte(8'h00); wrByte(8'h00); wrByte(8'h00); wrByte(8'h70);
    tick(4);
    chk("hold_wr_pulses", wrReadyCnt - c0, 32'd4);
    expBus.push_back(br(32'h7000_0000, 32'h0000_00AB, 1'b0));
    rdByte(got);
    chk("hold_rd_byte", {24'b0, got}, 32'h0000_00AB);
    pulseStop();

    // Partial write on stop: be 0011, no extra ready pulse
    pulseStart();
    wrByte(8'h00); wrByte(8'h01); wrByte(8'h00); wrByte(8'h40);
    wrByte(8'h55); wrByte(8'h66);
    expBus.push_back(bw(32'h4000_0100, 32'h0000_6655, 32'h0000_FFFF, 4'b0011, 1'b0));
    c1 = wrReadyCnt;
    pulseStop();
    n = 0;
    while (busy && n < 100) begin tick(1); n++; end
    chk("part_busy", {31'b0, busy}, 32'h0);
    tick(3);
    chk("part_no_ready", wrReadyCnt - c1, 32'd0);
    chk("part_bus_left", expBus.size(), 32'd0);

    // Read timeout: bus never acks
    pulseStart();
    wrByte(8'h00); wrByte(8'h00); wrByte(8'h00); wrByte(8'h50);
    expBus.push_back(br(32'h5000_0000, 32'h0, 1'b1));
    rdByte(got);
    chk("tmo_byte0", {24'b0, got}, 32'h0000_00EF);
    chk("tmo_req_cycles", lastReqCycles, 32'd1024);
    rdByte(got);
    chk("tmo_byte1", {24'b0, got}, 32'h0000_00BE);
    rdByte(got);
    chk("tmo_byte2", {24'b0, got}, 32'h0000_00AD);
    rdByte(got);
    chk("tmo_byte3", {24'b0, got}, 32'h0000_00DE);
    chk("tmo_err_sticky", {31'b0, err_sticky}, 32'h1);
    pulseStop();
    tick(2);
    chk("tmo_sticky_idle", {31'b0, err_sticky}, 32'h1);
    pulseStart();
    chk("tmo_sticky_clr", {31'b0, err_sticky}, 32'h0);
    pulseStop();
    tick(2);

    // Reset during BUS_WR
    pulseStart();
    wrByte(8'h00); wrByte(8'h00); wrByte(8'h00); wrByte(8'h60);
    wrByte(8'h01); wrByte(8'h02); wrByte(8'h03);
    expBus.push_back(bw(32'h6000_0000, 32'h0403_0201, 32'hFFFF_FFFF, 4'hF, 1'b1));
    c0 = wrReadyCnt;
    i2c_wr_data = 8'h04;
    i2c_wr_req = 1'b1;
    n = 0;
    while (!busIf.dbg_req && n < 50) begin @(negedge clk); n++; end
    chk("rstmid_req_seen", {31'b0, busIf.dbg_req}, 32'h1);
    tick(3);
    rstn = 1'b0;
    #1;
    chk("rstmid_dbg_req", {31'b0, busIf.dbg_req}, 32'h0);
    chk("rstmid_busy", {31'b0, busy}, 32'h0);
    chk("rstmid_wr_ready", {31'b0, i2c_wr_ready}, 32'h0);
    chk("rstmid_rd_ready", {31'b0, i2c_rd_ready}, 32'h0);
    chk("rstmid_withheld", wrReadyCnt - c0, 32'd0);
    i2c_wr_req = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick(2);
    pulseStart();
    expBus.push_back(br(32'h0000_0000, 32'hCAFE_F00D, 1'b0));
    rdByte(got);
    chk("rstmid_rd_ptr0", {24'b0, got}, 32'h0000_000D);
    pulseStop();
    tick(4);
    chk("final_bus_left", expBus.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
